// File: rtl/uart_tx_fifo_if.sv
// Bus bundle between the system-side byte writer and the uart_tx_fifo block.
// With UART_TX_FIFO_OVERFLOW_FLAG_EN defined the bundle also carries overflow/clr_overflow.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  uart_txready;
  logic                  uart_txen;
  logic [7:0]            uart_din;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  logic                  overflow;
  logic                  clr_overflow;

  modport master (
    output wr_en, wr_data, uart_txready, clr_overflow,
    input  full, empty, count, uart_txen, uart_din, overflow
  );
  modport slave (
    input  wr_en, wr_data, uart_txready, clr_overflow,
    output full, empty, count, uart_txen, uart_din, overflow
  );
`else
  modport master (
    output wr_en, wr_data, uart_txready,
    input  full, empty, count, uart_txen, uart_din
  );
  modport slave (
    input  wr_en, wr_data, uart_txready,
    output full, empty, count, uart_txen, uart_din
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a txen/din/txready handshake, one byte per frame.
// Optional sticky overflow flag is enabled by defining UART_TX_FIFO_OVERFLOW_FLAG_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_txen;
  logic [7:0]            r_din;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr    = bus.wr_en & ~w_full;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: wait for the UART to go busy, then idle again, before the next pop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!w_empty && bus.uart_txready) w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.uart_txready)            w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.uart_txready)             w_state_nxt = S_IDLE;
      default:                                       w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: a pop is only ever decided in IDLE
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = !w_empty && bus.uart_txready;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // UART load pulse and held byte
  always_ff @(posedge clock) begin
    if (reset) begin
      r_txen <= 1'b0;
      r_din  <= 8'h00;
    end else begin
      r_txen <= w_pop;
      if (w_pop) r_din <= r_mem[r_rd_ptr];
    end
  end

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.uart_txen = r_txen;
  assign bus.uart_din  = r_din;

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  logic r_overflow;

  // Sticky drop indicator; a new drop outranks a clear in the same cycle
  always_ff @(posedge clock) begin
    if (reset)                      r_overflow <= 1'b0;
    else if (bus.wr_en && w_full)   r_overflow <= 1'b1;
    else if (bus.clr_overflow)      r_overflow <= 1'b0;
  end

  assign bus.overflow = r_overflow;
`endif
endmodule
